// File: rtl/fphub_adder_arbiter.sv
// Round-robin front end for one shared fixed-latency FPHUB adder.
// Grants at most one operand pair per cycle and registers it into the adder.
// A tag pipeline follows each add and routes the sum back to its owner.
module fphub_adder_arbiter #(
    parameter int M     = 23,
    parameter int E     = 8,
    parameter int N_REQ = 4,
    parameter int LAT   = 3
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       en,
    input  logic [N_REQ-1:0]           req_valid,
    output logic [N_REQ-1:0]           req_ready,
    input  logic [N_REQ*(E+M+1)-1:0]   req_x,
    input  logic [N_REQ*(E+M+1)-1:0]   req_y,
    output logic                       add_valid,
    output logic [E+M:0]               add_x,
    output logic [E+M:0]               add_y,
    input  logic [E+M:0]               add_result,
    output logic [N_REQ-1:0]           res_valid,
    output logic [E+M:0]               res_data,
    output logic                       busy
);

    localparam int W     = E + M + 1;
    localparam int PTR_W = $clog2(N_REQ);

    // Round-robin pointer: the requester with the highest priority next cycle.
    logic [PTR_W-1:0] r_ptr;

    // Issue register feeding the adder.
    logic             r_add_valid;
    logic [W-1:0]     r_add_x;
    logic [W-1:0]     r_add_y;
    logic [N_REQ-1:0] r_add_own;

    // Tag pipeline: valid bits and one-hot owners, stage LAT-1 aligns with add_result.
    logic [LAT-1:0]   r_tag_vld;
    logic [N_REQ-1:0] r_tag_own [LAT];

    // Result register.
    logic [N_REQ-1:0] r_res_valid;
    logic [W-1:0]     r_res_data;

    // Arbiter outcome.
    logic             w_grant_any;
    logic [PTR_W-1:0] w_grant_idx;
    logic [N_REQ-1:0] w_grant;
    logic [PTR_W-1:0] w_ptr_next;

    // (p + k) mod N_REQ without relying on N_REQ being a power of two.
    function automatic logic [PTR_W-1:0] wrap_add(input logic [PTR_W-1:0] p, input int k);
        int s;
        s = int'(p) + k;
        if (s >= N_REQ) s = s - N_REQ;
        return s[PTR_W-1:0];
    endfunction

    // Search req_valid from the pointer, wrapping, and pick the first set bit.
    always_comb begin
        // NOTE: every output gets a default first so no path can infer a latch.
        w_grant_any = 1'b0;
        w_grant_idx = '0;
        w_grant     = '0;
        if (en) begin
            for (int k = 0; k < N_REQ; k++) begin
                if (!w_grant_any && req_valid[wrap_add(r_ptr, k)]) begin
                    w_grant_any = 1'b1;
                    w_grant_idx = wrap_add(r_ptr, k);
                end
            end
        end
        if (w_grant_any) w_grant[w_grant_idx] = 1'b1;
        w_ptr_next = wrap_add(w_grant_idx, 1);
    end

    assign req_ready = w_grant;

    // Register the winning operand pair and move the pointer past the winner.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ptr       <= '0;
            r_add_valid <= 1'b0;
            r_add_x     <= '0;
            r_add_y     <= '0;
            r_add_own   <= '0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples pre-edge values.
            r_add_valid <= w_grant_any;
            if (w_grant_any) begin
                r_add_x   <= req_x[w_grant_idx*W +: W];
                r_add_y   <= req_y[w_grant_idx*W +: W];
                r_add_own <= w_grant;
                r_ptr     <= w_ptr_next;
            end
        end
    end

    // Shift the tag valid bits every cycle, so disabling issue still drains the pipe.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tag_vld <= '0;
        end else begin
            r_tag_vld[0] <= r_add_valid;
            for (int k = 1; k < LAT; k++) begin
                r_tag_vld[k] <= r_tag_vld[k-1];
            end
        end
    end

    // Shift the owner tags alongside the valid bits.
    // NOTE: owner tags carry no reset; they are only looked at when their valid bit is set.
    always_ff @(posedge clk) begin
        r_tag_own[0] <= r_add_own;
        for (int k = 1; k < LAT; k++) begin
            r_tag_own[k] <= r_tag_own[k-1];
        end
    end

    // Capture the adder sum and raise the owner's strobe for one cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_res_valid <= '0;
            r_res_data  <= '0;
        end else if (r_tag_vld[LAT-1]) begin
            r_res_valid <= r_tag_own[LAT-1];
            r_res_data  <= add_result;
        end else begin
            r_res_valid <= '0;
        end
    end

    assign add_valid = r_add_valid;
    assign add_x     = r_add_x;
    assign add_y     = r_add_y;
    assign res_valid = r_res_valid;
    assign res_data  = r_res_data;
    assign busy      = r_add_valid | (|r_tag_vld);

endmodule

// File: tb/tb_fphub_adder_arbiter.sv
// Bench for fphub_adder_arbiter: a stub adder (registered X+Y, LAT deep) closes
// the loop, and a cycle-indexed scoreboard predicts grants, results and busy.
module tb_fphub_adder_arbiter;

    parameter int LAT = 3;
    localparam int M = 23;
    localparam int E = 8;
    localparam int N = 4;
    localparam int W = E + M + 1;

    logic             clk;
    logic             rst_n;
    logic             en;
    logic [N-1:0]     req_valid;
    logic [N-1:0]     req_ready;
    logic [N*W-1:0]   req_x;
    logic [N*W-1:0]   req_y;
    logic             add_valid;
    logic [W-1:0]     add_x;
    logic [W-1:0]     add_y;
    logic [W-1:0]     add_result;
    logic [N-1:0]     res_valid;
    logic [W-1:0]     res_data;
    logic             busy;

    fphub_adder_arbiter #(.M(M), .E(E), .N_REQ(N), .LAT(LAT)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .en         (en),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_x      (req_x),
        .req_y      (req_y),
        .add_valid  (add_valid),
        .add_x      (add_x),
        .add_y      (add_y),
        .add_result (add_result),
        .res_valid  (res_valid),
        .res_data   (res_data),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Stub adder: sum of the operands presented, delivered LAT cycles later.
    logic [W-1:0] stub_pipe [LAT];
    always @(posedge clk) begin
        stub_pipe[0] <= add_x + add_y;
        for (int k = 1; k < LAT; k++) stub_pipe[k] <= stub_pipe[k-1];
    end
    assign add_result = stub_pipe[LAT-1];

    // Scoreboard entry: edge index at which the result must appear, owner, sum.
    typedef struct {
        int           due;
        logic [N-1:0] own;
        logic [W-1:0] sum;
    } exp_t;

    exp_t q[$];
    int   m_ptr;
    int   cyc;
    int   n_tests;
    int   n_fail;

    // Round-robin rule: first valid requester at or after the pointer, wrapping.
    function automatic int model_grant(input logic [N-1:0] v, input logic e, input int p);
        if (!e) return -1;
        for (int k = 0; k < N; k++) begin
            if (v[(p + k) % N]) return (p + k) % N;
        end
        return -1;
    endfunction

    // One clock cycle of stimulus with full checking of the visible outputs.
    task automatic step(input logic [N-1:0] v, input logic e, input bit fixed_ops);
        int           g;
        logic [N-1:0] exp_rdy;
        logic [N-1:0] exp_rv;
        logic [W-1:0] exp_rd;
        logic [W-1:0] gx;
        logic [W-1:0] gy;
        req_valid = v;
        en        = e;
        for (int i = 0; i < N; i++) begin
            req_x[i*W +: W] = $urandom;
            req_y[i*W +: W] = $urandom;
        end
        if (fixed_ops) begin
            req_x[0 +: W] = 32'h3F80_0000;
            req_y[0 +: W] = 32'h4000_0000;
        end
        #1;
        g = model_grant(v, e, m_ptr);
        exp_rdy = '0;
        gx = '0;
        gy = '0;
        if (g >= 0) begin
            exp_rdy[g] = 1'b1;
            gx = req_x[g*W +: W];
            gy = req_y[g*W +: W];
        end
        n_tests++;
        if (req_ready !== exp_rdy) begin
            n_fail++;
            $display("FAIL req_ready cyc=%0d: got %b expected %b", cyc, req_ready, exp_rdy);
        end

        @(posedge clk);
        cyc++;
        if (g >= 0) begin
            q.push_back('{due: cyc + LAT + 1, own: exp_rdy, sum: gx + gy});
            m_ptr = (g + 1) % N;
        end

        @(negedge clk);
        n_tests++;
        if (add_valid !== (g >= 0)) begin
            n_fail++;
            $display("FAIL add_valid cyc=%0d: got %b expected %b", cyc, add_valid, g >= 0);
        end
        if (g >= 0) begin
            n_tests++;
            if (add_x !== gx || add_y !== gy) begin
                n_fail++;
                $display("FAIL add_xy cyc=%0d: got %h/%h expected %h/%h", cyc, add_x, add_y, gx, gy);
            end
        end
        exp_rv = '0;
        exp_rd = '0;
        if (q.size() > 0 && q[0].due == cyc) begin
            exp_rv = q[0].own;
            exp_rd = q[0].sum;
            void'(q.pop_front());
        end
        n_tests++;
        if (res_valid !== exp_rv) begin
            n_fail++;
            $display("FAIL res_valid cyc=%0d: got %b expected %b", cyc, res_valid, exp_rv);
        end
        if (exp_rv != '0) begin
            n_tests++;
            if (res_data !== exp_rd) begin
                n_fail++;
                $display("FAIL res_data cyc=%0d: got %h expected %h", cyc, res_data, exp_rd);
            end
        end
        n_tests++;
        if (busy !== (q.size() > 0)) begin
            n_fail++;
            $display("FAIL busy cyc=%0d: got %b expected %b", cyc, busy, q.size() > 0);
        end
    endtask

    task automatic drain(input int n);
        for (int i = 0; i < n; i++) step('0, 1'b1, 1'b0);
    endtask

    // Hold reset across an edge, check the idle state, release on a falling edge.
    task automatic test_reset();
        rst_n     = 1'b0;
        req_valid = '0;
        en        = 1'b0;
        @(posedge clk);
        @(negedge clk);
        n_tests++;
        if ({add_valid, busy, req_ready, res_valid} !== '0) begin
            n_fail++;
            $display("FAIL reset_ctrl: got av=%b busy=%b rdy=%b rv=%b expected all 0",
                     add_valid, busy, req_ready, res_valid);
        end
        n_tests++;
        if ({add_x, add_y, res_data} !== '0) begin
            n_fail++;
            $display("FAIL reset_data: got x=%h y=%h rd=%h expected all 0", add_x, add_y, res_data);
        end
        rst_n = 1'b1;
        q.delete();
        m_ptr = 0;
    endtask

    task automatic test_single();
        step(4'b0001, 1'b1, 1'b1);
        drain(LAT + 3);
    endtask

    task automatic test_all_valid();
        test_reset();
        for (int i = 0; i < 8; i++) step(4'b1111, 1'b1, 1'b0);
        drain(LAT + 3);
    endtask

    task automatic test_enable();
        for (int i = 0; i < 3; i++) step(4'b1111, 1'b1, 1'b0);
        for (int i = 0; i < 2; i++) step(4'b1111, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) step(4'b1111, 1'b1, 1'b0);
        // Long disable with requests pending: pipe must drain and busy drop.
        for (int i = 0; i < LAT + 4; i++) step(4'b1111, 1'b0, 1'b0);
        for (int i = 0; i < 2; i++) step(4'b1111, 1'b1, 1'b0);
        drain(LAT + 3);
    endtask

    task automatic test_sparse();
        for (int i = 0; i < 8; i++) step(4'b1010, 1'b1, 1'b0);
        drain(LAT + 3);
    endtask

    task automatic test_reset_mid_flight();
        for (int i = 0; i < 3; i++) step(4'b1111, 1'b1, 1'b0);
        req_valid = '0;
        rst_n     = 1'b0;
        #1;
        n_tests++;
        if ({add_valid, busy, req_ready, res_valid} !== '0) begin
            n_fail++;
            $display("FAIL midreset_ctrl: got av=%b busy=%b rdy=%b rv=%b expected all 0",
                     add_valid, busy, req_ready, res_valid);
        end
        n_tests++;
        if ({add_x, add_y, res_data} !== '0) begin
            n_fail++;
            $display("FAIL midreset_data: got x=%h y=%h rd=%h expected all 0", add_x, add_y, res_data);
        end
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        q.delete();
        m_ptr = 0;
        drain(10);
        step(4'b0100, 1'b1, 1'b0);
        drain(LAT + 3);
    endtask

    task automatic test_random();
        for (int i = 0; i < 150; i++) begin
            step(4'($urandom_range(0, 15)), ($urandom_range(0, 3) != 0), 1'b0);
        end
        drain(LAT + 3);
    endtask

    initial begin
        n_tests   = 0;
        n_fail    = 0;
        cyc       = 0;
        m_ptr     = 0;
        rst_n     = 1'b0;
        en        = 1'b0;
        req_valid = '0;
        req_x     = '0;
        req_y     = '0;
        @(negedge clk);
        test_reset();
        test_single();
        test_all_valid();
        test_enable();
        test_sparse();
        test_reset_mid_flight();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
